// File: rtl/load_store_unit_if.sv
// Pipeline request and data-memory bus for the load/store unit.
// The slave modport is the unit itself; the master modport is its environment.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [31:0] base_addr;
  logic [31:0] offset_ext;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        done;
  logic        align_err;
  logic        timeout_err;
  logic        stall;

  modport slave (
    input  req_valid, req_is_store, base_addr, offset_ext, store_data,
    input  mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output load_data, done, align_err, timeout_err, stall
  );

  modport master (
    output req_valid, req_is_store, base_addr, offset_ext, store_data,
    output mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  load_data, done, align_err, timeout_err, stall
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: effective address, alignment check and a
// req/ack handshake to data memory with an optional ack timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CNT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              done_q, done_d;
  logic              align_err_q, align_err_d;
  logic              timeout_err_q, timeout_err_d;
  logic              req_ready_q, req_ready_d;
  logic              stall_q, stall_d;
  logic [31:0]       eff_addr;

  // Next state and registered outputs; carry out of the address add is dropped.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    load_data_d   = load_data_q;
    done_d        = 1'b0;
    align_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    eff_addr      = bus.base_addr + bus.offset_ext;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (eff_addr[1:0] != 2'b00) begin
            state_d     = ERR;
            align_err_d = 1'b1;
          end else begin
            state_d     = ACCESS;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_is_store;
            mem_addr_d  = eff_addr;
            mem_wdata_d = bus.req_is_store ? bus.store_data : 32'h0;
          end
        end
      end
      ACCESS: begin
        if (bus.mem_ack) begin
          state_d     = DONE;
          done_d      = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wdata_d = 32'h0;
          if (!mem_we_q) load_data_d = bus.mem_rdata;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(CNT_LAST))) begin
          state_d       = ERR;
          timeout_err_d = 1'b1;
          mem_req_d     = 1'b0;
          mem_we_d      = 1'b0;
          mem_wdata_d   = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    stall_d     = (state_d != IDLE);
  end

  // State and output registers; reset drops mem_req without waiting for an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_wdata_q   <= 32'h0;
      load_data_q   <= 32'h0;
      done_q        <= 1'b0;
      align_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      req_ready_q   <= 1'b1;
      stall_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      load_data_q   <= load_data_d;
      done_q        <= done_d;
      align_err_q   <= align_err_d;
      timeout_err_q <= timeout_err_d;
      req_ready_q   <= req_ready_d;
      stall_q       <= stall_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.stall       = stall_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.load_data   = load_data_q;
  assign bus.done        = done_q;
  assign bus.align_err   = align_err_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected
// memory and response records; independent monitors pop and compare them.
module tb_load_store_unit;

  typedef struct {
    logic [2:0]  flags;   // {done, align_err, timeout_err}
    logic [31:0] ld;
    int          lat;
    int          issue;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          ncyc;
  } mem_t;

  logic clk;
  logic rst;
  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  resp_t exp_resp[$];
  mem_t  exp_mem[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  int    ack_at = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: acks on the ack_at-th cycle of a request, never if ack_at == 0.
  initial begin
    int rcnt;
    rcnt = 0;
    bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !rst) begin
        rcnt++;
        bus.mem_ack = (ack_at != 0) && (rcnt == ack_at);
      end else begin
        rcnt = 0;
        bus.mem_ack = 1'b0;
      end
    end
  end

  // Memory-side monitor: address/control at request start, stability, length and release.
  initial begin
    mem_t cur;
    logic mprev;
    int   mcyc;
    mprev = 1'b0;
    mcyc  = 0;
    cur   = '{32'h0, 1'b0, 32'h0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        mprev = 1'b0;
        mcyc  = 0;
      end else if (bus.mem_req) begin
        if (!mprev) begin
          mcyc = 0;
          if (exp_mem.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mem_req: got addr %h expected no request", bus.mem_addr);
          end else begin
            cur = exp_mem.pop_front();
            chk("mem_addr", bus.mem_addr, cur.addr);
            chk("mem_we", 32'(bus.mem_we), 32'(cur.we));
            chk("mem_wdata", bus.mem_wdata, cur.wdata);
          end
        end else begin
          chk("mem_addr_stable", bus.mem_addr, cur.addr);
        end
        mcyc++;
        mprev = 1'b1;
      end else if (mprev) begin
        chk("mem_req_cycles", 32'(mcyc), 32'(cur.ncyc));
        chk("mem_we_released", 32'(bus.mem_we), 32'h0);
        chk("mem_wdata_released", bus.mem_wdata, 32'h0);
        chk("mem_addr_held", bus.mem_addr, cur.addr);
        mprev = 1'b0;
      end
    end
  end

  // Response monitor: every done/error pulse must match the next expected record.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (!rst && (bus.done || bus.align_err || bus.timeout_err)) begin
        if (exp_resp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_response: got flags %b expected none",
                   {bus.done, bus.align_err, bus.timeout_err});
        end else begin
          r = exp_resp.pop_front();
          chk("resp_flags", 32'({bus.done, bus.align_err, bus.timeout_err}), 32'(r.flags));
          chk("load_data", bus.load_data, r.ld);
          chk("latency", 32'(cyc - r.issue), 32'(r.lat));
        end
      end
    end
  end

  // Issue one request (called at a negedge) and wait, bounded, for its response.
  task automatic issue(input logic st, input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] data, input logic [31:0] rd, input int ack,
                       input logic [31:0] exp_addr, input logic [2:0] flags,
                       input logic [31:0] exp_ld, input int lat, input int ncyc);
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ack_at            = ack;
    bus.mem_rdata     = rd;
    bus.req_is_store  = st;
    bus.base_addr     = base;
    bus.offset_ext    = off;
    bus.store_data    = data;
    bus.req_valid     = 1'b1;
    exp_resp.push_back('{flags, exp_ld, lat, cyc});
    if (flags != 3'b010) exp_mem.push_back('{exp_addr, st, st ? data : 32'h0, ncyc});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    while (exp_resp.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_resp.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL response_wait: got no response after %0d cycles expected one", n);
      exp_resp.delete();
      exp_mem.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.base_addr    = 32'h0;
    bus.offset_ext   = 32'h0;
    bus.store_data   = 32'h0;
    bus.mem_rdata    = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_load_data", bus.load_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Load with negative offset, ack on third request cycle
    issue(1'b0, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0, 32'hDEAD_BEEF, 3,
          32'h0000_0FFC, 3'b100, 32'hDEAD_BEEF, 4, 3);
    // Store with immediate ack; load_data keeps the previous load
    issue(1'b1, 32'h0000_2000, 32'h0000_0010, 32'h1234_5678, 32'hA5A5_A5A5, 1,
          32'h0000_2010, 3'b100, 32'hDEAD_BEEF, 2, 1);
    // Address wrap-around
    issue(1'b0, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 2,
          32'h0000_0004, 3'b100, 32'hCAFE_F00D, 3, 2);
    // Misaligned: no memory request, align_err one cycle after accept
    issue(1'b0, 32'h0000_1000, 32'h0000_0002, 32'h0, 32'h1111_1111, 1,
          32'h0, 3'b010, 32'hCAFE_F00D, 1, 0);
    chk("ready_after_align", 32'(bus.req_ready), 32'h1);
    // Timeout: 16 request cycles, then timeout_err
    issue(1'b1, 32'h0000_3000, 32'h0000_0000, 32'h8765_4321, 32'h0, 0,
          32'h0000_3000, 3'b001, 32'hCAFE_F00D, 17, 16);

    // Reset in the middle of an access
    ack_at           = 0;
    bus.req_is_store = 1'b0;
    bus.base_addr    = 32'h0000_0200;
    bus.offset_ext   = 32'h0;
    bus.req_valid    = 1'b1;
    exp_mem.push_back('{32'h0000_0200, 1'b0, 32'h0, 0});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_mem_req", 32'(bus.mem_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("async_rst_stall", 32'(bus.stall), 32'h0);
    chk("async_rst_req_ready", 32'(bus.req_ready), 32'h1);
    chk("async_rst_load_data", bus.load_data, 32'h0);
    exp_mem.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'h0000_0100, 32'h0000_0004, 32'h0, 32'h55AA_55AA, 1,
          32'h0000_0104, 3'b100, 32'h55AA_55AA, 2, 1);

    repeat (3) @(negedge clk);
    if (exp_mem.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL mem_queue_drained: got %0d pending expected 0", exp_mem.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
